// File: rtl/mix_route_sequencer.sv
// Sequences inlet valve, pump A, rotary mixer, pump C and outlet valve for one fluidic job.
// Latency: job starts the cycle after accept; every output is registered.
// Backpressure: cmd_ready is high only while idle; abort cancels any active job.
module mix_route_sequencer #(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 5,
    parameter int STROKE_W   = 8,
    parameter int PHASE_CYC  = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(N_IN)-1:0]  cmd_src,
    input  logic [$clog2(N_OUT)-1:0] cmd_dst,
    input  logic [STROKE_W-1:0]      cmd_fill,
    input  logic [STROKE_W-1:0]      cmd_mix,
    input  logic [STROKE_W-1:0]      cmd_drain,
    input  logic                     abort,
    output logic [N_IN-1:0]          in_valve,
    output logic [N_OUT-1:0]         out_valve,
    output logic [2:0]               pump_a,
    output logic [2:0]               pump_c,
    output logic [2:0]               mix_ctl,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     err
);
    localparam int SRC_W = $clog2(N_IN);
    localparam int DST_W = $clog2(N_OUT);
    localparam int TMAX  = (PHASE_CYC > SETTLE_CYC) ? PHASE_CYC : SETTLE_CYC;
    localparam int TW    = $clog2(TMAX + 1);
    localparam logic [TW-1:0]       SET_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]       PH_LAST  = TW'(PHASE_CYC - 1);
    localparam logic [STROKE_W-1:0] ONE      = STROKE_W'(1);

    typedef enum logic [2:0] {IDLE, SETTLE_IN, FILL, MIX, SETTLE_OUT, DRAIN} state_t;

    state_t                state, n_state;
    logic [TW-1:0]         tmr, n_tmr;
    logic [1:0]            ph, n_ph;
    logic [STROKE_W-1:0]   strk, n_strk;
    logic [SRC_W-1:0]      src_q, n_src;
    logic [DST_W-1:0]      dst_q, n_dst;
    logic [STROKE_W-1:0]   fill_q, n_fill, mix_q, n_mix, drain_q, n_drain;
    logic [N_IN-1:0]       n_in_valve;
    logic [N_OUT-1:0]      n_out_valve;
    logic [2:0]            n_pump_a, n_pump_c, n_mix_ctl;
    logic                  n_done, n_aborted, n_err;

    function automatic logic [2:0] pat(input logic [1:0] p);
        case (p)
            2'd0:    pat = 3'b011;
            2'd1:    pat = 3'b101;
            default: pat = 3'b110;
        endcase
    endfunction

    always_comb begin
        n_state   = state;
        n_tmr     = tmr + TW'(1);
        n_ph      = ph;
        n_strk    = strk;
        n_src     = src_q;
        n_dst     = dst_q;
        n_fill    = fill_q;
        n_mix     = mix_q;
        n_drain   = drain_q;
        n_done    = 1'b0;
        n_aborted = 1'b0;
        n_err     = 1'b0;

        case (state)
            IDLE: begin
                n_tmr = '0;
                if (cmd_valid && cmd_ready) begin
                    if (int'(cmd_src) >= N_IN || int'(cmd_dst) >= N_OUT) begin
                        n_err = 1'b1;
                    end else begin
                        n_src   = cmd_src;
                        n_dst   = cmd_dst;
                        n_fill  = cmd_fill;
                        n_mix   = cmd_mix;
                        n_drain = cmd_drain;
                        n_state = SETTLE_IN;
                    end
                end
            end
            SETTLE_IN: begin
                if (tmr == SET_LAST)
                    n_state = (fill_q != '0) ? FILL : (mix_q != '0) ? MIX : SETTLE_OUT;
            end
            SETTLE_OUT: begin
                if (tmr == SET_LAST)
                    n_state = (drain_q != '0) ? DRAIN : IDLE;
            end
            default: begin
                // FILL / MIX / DRAIN: PHASE_CYC clocks per phase, three phases per stroke
                if (tmr == PH_LAST) begin
                    n_tmr = '0;
                    if (ph == 2'd2) begin
                        n_ph   = 2'd0;
                        n_strk = strk - ONE;
                        if (strk == ONE) begin
                            case (state)
                                FILL:    n_state = (mix_q != '0) ? MIX : SETTLE_OUT;
                                MIX:     n_state = SETTLE_OUT;
                                default: n_state = IDLE;
                            endcase
                        end
                    end else begin
                        n_ph = ph + 2'd1;
                    end
                end
            end
        endcase

        if (state != IDLE && n_state == IDLE)
            n_done = 1'b1;

        if (state != IDLE && abort) begin
            n_state   = IDLE;
            n_done    = 1'b0;
            n_aborted = 1'b1;
        end

        if (n_state != state) begin
            n_tmr = '0;
            n_ph  = 2'd0;
            case (n_state)
                FILL:    n_strk = n_fill;
                MIX:     n_strk = n_mix;
                DRAIN:   n_strk = n_drain;
                default: n_strk = '0;
            endcase
        end

        n_in_valve  = '0;
        n_out_valve = '0;
        n_pump_a    = 3'b000;
        n_pump_c    = 3'b000;
        n_mix_ctl   = 3'b000;
        case (n_state)
            SETTLE_IN:  n_in_valve[n_src] = 1'b1;
            FILL: begin
                n_in_valve[n_src] = 1'b1;
                n_pump_a          = pat(n_ph);
                n_mix_ctl         = 3'b111;
            end
            MIX:        n_mix_ctl = pat(n_ph);
            SETTLE_OUT: n_out_valve[n_dst] = 1'b1;
            DRAIN: begin
                n_out_valve[n_dst] = 1'b1;
                n_pump_c           = pat(n_ph);
                n_mix_ctl          = 3'b111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            ph        <= 2'd0;
            strk      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            fill_q    <= '0;
            mix_q     <= '0;
            drain_q   <= '0;
            in_valve  <= '0;
            out_valve <= '0;
            pump_a    <= 3'b000;
            pump_c    <= 3'b000;
            mix_ctl   <= 3'b000;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= n_state;
            tmr       <= n_tmr;
            ph        <= n_ph;
            strk      <= n_strk;
            src_q     <= n_src;
            dst_q     <= n_dst;
            fill_q    <= n_fill;
            mix_q     <= n_mix;
            drain_q   <= n_drain;
            in_valve  <= n_in_valve;
            out_valve <= n_out_valve;
            pump_a    <= n_pump_a;
            pump_c    <= n_pump_c;
            mix_ctl   <= n_mix_ctl;
            busy      <= (n_state != IDLE);
            cmd_ready <= (n_state == IDLE);
            done      <= n_done;
            aborted   <= n_aborted;
            err       <= n_err;
        end
    end
endmodule
